// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 8-digit BCD display scanner.
// One digit slot lasts SCAN_DIV clocks; eight slots form a frame. The BCD
// word and both masks are snapshotted when slot 0 begins, so a frame never
// mixes two input values. Digits flagged in blink_mask go dark every other
// BLINK_FRAMES-frame period. All outputs are registered.
// Optional feature: define SEG_SCAN_LZB_EN for leading-zero blanking.

module seg_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] digits,
    input  logic [7:0]  blink_mask,
    input  logic [7:0]  dp_mask,
    input  logic        enable,
    output logic [7:0]  an,
    output logic [3:0]  digit,
    output logic        dp,
    output logic        frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    // State registers
    logic [PW-1:0] pre;
    logic [2:0]    slot;
    logic [FW-1:0] frame_cnt;
    logic          phase;        // 1 = blinking digits dark
    logic          running;      // set by the first tick after reset
    logic [31:0]   digits_snap;
    logic [7:0]    blink_snap;
    logic [7:0]    dp_snap;

    // Next-state values
    logic          tick;
    logic          frame_tick;
    logic [PW-1:0] pre_n;
    logic [2:0]    slot_n;
    logic [FW-1:0] frame_cnt_n;
    logic          phase_n;
    logic          running_n;
    logic [31:0]   digits_snap_n;
    logic [7:0]    blink_snap_n;
    logic [7:0]    dp_snap_n;
    logic [7:0]    blank;
    logic          lit;

    assign tick       = (pre == PRE_LAST);
    assign frame_tick = tick && (slot == 3'd7);

    // Next-state: prescaler, slot stepping, frame snapshot and blink phase.
    // Outputs are derived from these next values so the new slot, snapshot
    // and phase all appear together one cycle after the tick.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; a missing default in always_comb infers a latch.
        pre_n         = tick ? '0 : pre + PW'(1);
        slot_n        = slot;
        frame_cnt_n   = frame_cnt;
        phase_n       = phase;
        running_n     = running | tick;
        digits_snap_n = digits_snap;
        blink_snap_n  = blink_snap;
        dp_snap_n     = dp_snap;
        if (tick) begin
            slot_n = slot + 3'd1;
        end
        if (frame_tick) begin
            digits_snap_n = digits;
            blink_snap_n  = blink_mask;
            dp_snap_n     = dp_mask;
            if (frame_cnt == FRM_LAST) begin
                frame_cnt_n = '0;
                phase_n     = ~phase;
            end else begin
                frame_cnt_n = frame_cnt + FW'(1);
            end
        end
    end

    // Leading-zero blanking mask, evaluated on the (next) snapshot so it is
    // constant for a whole frame.
    always_comb begin
        blank = 8'h00;
`ifdef SEG_SCAN_LZB_EN
        begin
            logic zero_above;
            zero_above = 1'b1;
            for (int i = 7; i >= 1; i--) begin
                zero_above = zero_above && (digits_snap_n[4*i +: 4] == 4'h0)
                             && !dp_snap_n[i];
                blank[i]   = zero_above;
            end
        end
`endif
    end

    // Lit decision for the slot shown next cycle; enable acts immediately.
    always_comb begin
        lit = enable && running_n
              && !(blink_snap_n[slot_n] && phase_n)
              && !blank[slot_n];
    end

    // Scan state registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) begin
            pre         <= '0;
            slot        <= 3'd0;
            frame_cnt   <= '0;
            phase       <= 1'b0;
            running     <= 1'b0;
            digits_snap <= 32'h0;
            blink_snap  <= 8'h00;
            dp_snap     <= 8'h00;
        end else begin
            pre         <= pre_n;
            slot        <= slot_n;
            frame_cnt   <= frame_cnt_n;
            phase       <= phase_n;
            running     <= running_n;
            digits_snap <= digits_snap_n;
            blink_snap  <= blink_snap_n;
            dp_snap     <= dp_snap_n;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an          <= 8'hFF;
            digit       <= 4'h0;
            dp          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            an          <= lit ? ~(8'b1 << slot_n) : 8'hFF;
            digit       <= digits_snap_n[{slot_n, 2'b00} +: 4];
            dp          <= dp_snap_n[slot_n];
            frame_start <= frame_tick;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed + randomized bench for seg_scan_driver.
// The reference model counts clock edges since reset release and derives
// slot, frame number, snapshot and blink phase arithmetically.
// Honours SEG_SCAN_LZB_EN when the design is built with it.

module tb_seg_scan_driver;

    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] digits;
    logic [7:0]  blink_mask;
    logic [7:0]  dp_mask;
    logic        enable;
    logic [7:0]  an;
    logic [3:0]  digit;
    logic        dp;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    // Model state: edges since reset release, frame snapshot, sampled enable
    int          e    = 0;
    logic [31:0] m_d  = 32'h0;
    logic [7:0]  m_b  = 8'h00;
    logic [7:0]  m_p  = 8'h00;
    logic        m_en = 1'b0;

    seg_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk         (clk),
        .reset       (reset),
        .digits      (digits),
        .blink_mask  (blink_mask),
        .dp_mask     (dp_mask),
        .enable      (enable),
        .an          (an),
        .digit       (digit),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Model update at each active edge.
    always @(posedge clk) begin
        if (reset) begin
            e   = 0;
            m_d = 32'h0;
            m_b = 8'h00;
            m_p = 8'h00;
        end else begin
            e    = e + 1;
            m_en = enable;
            if (e % SD == 0 && (e / SD) % 8 == 0) begin
                m_d = digits;
                m_b = blink_mask;
                m_p = dp_mask;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int          n, slot, f;
        logic        lit;
        logic [7:0]  exp_an;
        logic [31:0] shifted;
        n    = e / SD;
        slot = n % 8;
        f    = n / 8;
        lit  = m_en && (n >= 1) && !(m_b[slot] && ((f / BF) % 2 == 1));
`ifdef SEG_SCAN_LZB_EN
        begin
            logic blank;
            blank = (slot != 0);
            for (int j = slot; j < 8; j++)
                if (m_d[4*j +: 4] != 4'h0 || m_p[j]) blank = 1'b0;
            if (blank) lit = 1'b0;
        end
`endif
        exp_an  = lit ? ~(8'h01 << slot) : 8'hFF;
        shifted = m_d >> (4 * slot);
        check($sformatf("an e=%0d", e), {24'h0, an}, {24'h0, exp_an});
        check($sformatf("digit e=%0d", e), {28'h0, digit}, {28'h0, shifted[3:0]});
        check($sformatf("dp e=%0d", e), {31'h0, dp}, {31'h0, m_p[slot]});
        check($sformatf("frame_start e=%0d", e), {31'h0, frame_start},
              {31'h0, (e % SD == 0) && (n % 8 == 0) && (n > 0)});
    endtask

    task automatic run_cycles(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            check_outputs();
        end
    endtask

    // Advance (bounded) until the model reaches the given slot and phase.
    task automatic run_until_slot(input int s, input int sub);
        for (int i = 0; i < 8 * SD * 2; i++) begin
            if ((e / SD) % 8 == s && e % SD == sub && e >= SD) break;
            @(negedge clk);
            check_outputs();
        end
    endtask

    initial begin
        reset      = 1'b1;
        digits     = 32'h0;
        blink_mask = 8'h00;
        dp_mask    = 8'h00;
        enable     = 1'b1;

        // Reset state
        run_cycles(3);

        // Slot stepping
        @(negedge clk);
        reset  = 1'b0;
        digits = 32'h87654321;
        run_cycles(3 * 8 * SD + 5);

        // Snapshot coherence: inputs change mid-frame, then every cycle
        run_until_slot(3, 1);
        digits = 32'h00000000;
        run_cycles(8 * SD + 8);
        for (int i = 0; i < 2 * 8 * SD; i++) begin
            digits = $urandom;
            run_cycles(1);
        end

        // Blink on digits 0-1
        blink_mask = 8'h03;
        digits     = 32'h87654321;
        run_cycles(2 * 8 * SD);
        for (int i = 0; i < 4 * 8 * SD; i++) begin
            digits = $urandom;
            run_cycles(1);
        end
        blink_mask = 8'h00;

        // Enable low, decimal point on digit 2
        enable  = 1'b0;
        dp_mask = 8'h04;
        run_cycles(8 * SD + 8);
        enable = 1'b1;
        run_cycles(8 * SD + 8);

        // Randomized mix of all inputs
        for (int i = 0; i < 10 * 8 * SD; i++) begin
            digits     = $urandom;
            blink_mask = 8'($urandom);
            dp_mask    = 8'($urandom);
            enable     = ($urandom % 8) != 0;
            run_cycles(1);
        end

        // Asynchronous reset mid-slot 5, no clock edge
        digits     = 32'h87654321;
        blink_mask = 8'h00;
        dp_mask    = 8'h00;
        enable     = 1'b1;
        run_until_slot(5, 1);
        #2 reset = 1'b1;
        #1;
        check("async_an", {24'h0, an}, 32'hFF);
        check("async_digit", {28'h0, digit}, 32'h0);
        check("async_dp", {31'h0, dp}, 32'h0);
        run_cycles(2);
        @(negedge clk);
        reset = 1'b0;
        run_cycles(2 * 8 * SD + 4);

        // Leading zeros (blanked only when SEG_SCAN_LZB_EN is defined)
        digits = 32'h00001230;
        run_cycles(2 * 8 * SD);
        digits = 32'h00000000;
        run_cycles(2 * 8 * SD);
        dp_mask = 8'h10;
        run_cycles(2 * 8 * SD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
